cu_useq: RTL and testbench

//  Microcode sequencer for the CPU control unit. Owns the micro-PC (uPC) and addresses the external microcode ROM.

---
 rtl/cu_pkg.sv | 31 +++
 rtl/cu_dispatch_map.sv | 13 +
 rtl/cu_useq.sv | 144 ++++++++++++++
 tb/tb_cu_useq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the CPU control-unit microcode sequencer: microword
// field positions, advance codes, the NOP word and the write-enable mask.
package cu_pkg;

  localparam int CS_W      = 65;
  localparam int DB_NREAD  = 32;
  localparam int DB_NWRITE = 4;
  localparam int ADV_LSB   = 30;
  localparam int ADV_MSB   = 31;

  localparam logic [1:0] ADV_NEXT     = 2'b00;
  localparam logic [1:0] ADV_DISPATCH = 2'b01;
  localparam logic [1:0] ADV_COND     = 2'b10;
  localparam logic [1:0] ADV_END      = 2'b11;

  // Both bus strobes are active-low, so an idle word has them set.
  localparam logic [CS_W-1:0] CS_NOP = (65'd1 << DB_NREAD) | (65'd1 << DB_NWRITE);

  localparam logic [CS_W-1:0] CS_WE_MASK =
    (65'd1 << 21) | (65'd1 << 28) | (65'd1 << 29) | (65'd1 << 39) |
    (65'd1 << 40) | (65'd1 << 41) | (65'd1 << 42) | (65'd1 << 52) |
    (65'd1 << 55) | (65'd1 << 56) | (65'd1 << 62) | (65'd1 << 63) |
    (65'd1 << 64);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} useq_state_e;

  function automatic logic [4:0] lowest_bit(input logic [4:0] v);
    return v & (~v + 5'd1);
  endfunction

endpackage

// File: rtl/cu_dispatch_map.sv
// Opcode dispatch map: {cb_mode, opcode} -> entry uPC of the opcode routine.
module cu_dispatch_map #(
  parameter int UPC_W = 10
) (
  input  logic             cb_mode,
  input  logic [7:0]       opcode,
  output logic [UPC_W-1:0] entry
);

  // Two microwords reserved per opcode; the CB table takes the upper half.
  assign entry = UPC_W'({cb_mode, opcode, 1'b0});

endmodule

// File: rtl/cu_useq.sv
// Microcode sequencer: owns the uPC, inserts bus wait states, handles CB prefix
// and HALT. Optional interrupt entry at END is enabled by CU_INTERRUPT_EN.
module cu_useq
  import cu_pkg::*;
#(
  parameter int               UPC_W       = 10,
  parameter logic [UPC_W-1:0] FETCH_UADDR = '0,
  parameter logic [UPC_W-1:0] INT_UADDR   = UPC_W'(10'h3F0)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [UPC_W-1:0] urom_addr,
  input  logic [CS_W-1:0]  urom_data,
  output logic [CS_W-1:0]  control_signals,
  input  logic [7:0]       inst_byte,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             mem_ready,
  input  logic             wake,
  input  logic [4:0]       irq_req,
  input  logic             ime,
  output logic [4:0]       irq_ack,
  output logic             halted,
  output logic             cb_mode
);

  useq_state_e      state, state_nx;
  logic [UPC_W-1:0] upc, upc_nx, disp_entry;
  logic [7:0]       op_q, op_nx;
  logic             cb_q, cb_nx;
  logic [4:0]       ack_q, ack_nx;
  logic [1:0]       adv;
  logic             bus_act, stall, cond_ok;
  logic             end_int, wake_int;
  logic [4:0]       int_vec;

`ifdef CU_INTERRUPT_EN
  assign end_int  = ime & (|irq_req);
  assign wake_int = ime;
  assign int_vec  = lowest_bit(irq_req);
`else
  logic unused_irq;
  assign unused_irq = ^{irq_req, ime};
  assign end_int    = 1'b0;
  assign wake_int   = 1'b0;
  assign int_vec    = '0;
`endif

  assign adv     = urom_data[ADV_MSB:ADV_LSB];
  assign bus_act = ~urom_data[DB_NREAD] | ~urom_data[DB_NWRITE];
  assign stall   = (state != ST_HALT) & bus_act & ~mem_ready;

  cu_dispatch_map #(.UPC_W(UPC_W)) u_map (
    .cb_mode (cb_q),
    .opcode  (inst_byte),
    .entry   (disp_entry)
  );

  // Condition code comes from the opcode latched at dispatch: NZ, Z, NC, C.
  always_comb begin
    cond_ok = 1'b0;
    unique case (op_q[4:3])
      2'b00:   cond_ok = ~flag_z;
      2'b01:   cond_ok = flag_z;
      2'b10:   cond_ok = ~flag_c;
      default: cond_ok = flag_c;
    endcase
  end

  always_comb begin
    state_nx = state;
    upc_nx   = upc;
    op_nx    = op_q;
    cb_nx    = cb_q;
    ack_nx   = '0;
    if (state == ST_HALT) begin
      upc_nx = FETCH_UADDR;
      if (wake) begin
        state_nx = ST_RUN;
        if (wake_int) begin
          upc_nx = INT_UADDR;
          ack_nx = int_vec;
          cb_nx  = 1'b0;
        end
      end
    end else if (stall) begin
      state_nx = ST_WAIT;
    end else begin
      state_nx = ST_RUN;
      unique case (adv)
        ADV_NEXT: upc_nx = upc + UPC_W'(1);
        ADV_DISPATCH: begin
          upc_nx = disp_entry;
          op_nx  = inst_byte;
          cb_nx  = (inst_byte == 8'hCB) & ~cb_q;
          if (~cb_q && inst_byte == 8'h76) begin
            state_nx = ST_HALT;
            upc_nx   = FETCH_UADDR;
          end
        end
        ADV_COND: upc_nx = cond_ok ? upc + UPC_W'(1) : FETCH_UADDR;
        default: begin
          upc_nx = FETCH_UADDR;
          if (end_int) begin
            upc_nx = INT_UADDR;
            ack_nx = int_vec;
            cb_nx  = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
      upc   <= FETCH_UADDR;
      op_q  <= '0;
      cb_q  <= 1'b0;
      ack_q <= '0;
    end else begin
      state <= state_nx;
      upc   <= upc_nx;
      op_q  <= op_nx;
      cb_q  <= cb_nx;
      ack_q <= ack_nx;
    end
  end

  // Stalled writes are suppressed until the bus completes; reset and HALT idle the bus.
  always_comb begin
    control_signals = urom_data;
    if (reset || state == ST_HALT)
      control_signals = CS_NOP;
    else if (stall)
      control_signals = urom_data & ~CS_WE_MASK;
  end

  assign urom_addr = upc;
  assign halted    = (state == ST_HALT);
  assign cb_mode   = cb_q;
  assign irq_ack   = ack_q;

endmodule

// File: tb/tb_cu_useq.sv
// Self-checking bench for cu_useq: directed steps then randomized microcode,
// compared each cycle against a behavioural model of the sequencing rules.
module tb_cu_useq;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  urom_addr;
  logic [64:0] urom_data, control_signals;
  logic [7:0]  inst_byte;
  logic        flag_z, flag_c, mem_ready, wake, ime, halted, cb_mode;
  logic [4:0]  irq_req, irq_ack;

  logic [64:0] rom [0:1023];
  assign urom_data = rom[urom_addr];

  cu_useq dut (
    .clock(clock), .reset(reset), .urom_addr(urom_addr), .urom_data(urom_data),
    .control_signals(control_signals), .inst_byte(inst_byte), .flag_z(flag_z),
    .flag_c(flag_c), .mem_ready(mem_ready), .wake(wake), .irq_req(irq_req),
    .ime(ime), .irq_ack(irq_ack), .halted(halted), .cb_mode(cb_mode)
  );

  initial forever #5 clock = ~clock;

`ifdef CU_INTERRUPT_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [64:0] nop_c, we_c;
  int we_bits [13] = '{21, 28, 29, 39, 40, 41, 42, 52, 55, 56, 62, 63, 64};

  // Reference model: only what is architecturally visible.
  int         m_upc;
  bit         m_halt, m_cb;
  logic [7:0] m_op;
  logic [4:0] m_ack;

  logic [64:0] last_cs;
  int          last_addr;
  logic        last_halted, last_cb;
  logic [4:0]  last_ack;

  function automatic logic [64:0] mkw(input logic [1:0] adv, input bit rd, input bit wr);
    logic [64:0] r;
    r = '0;
    r[31:30] = adv;
    r[32] = ~rd;
    r[4]  = ~wr;
    return r;
  endfunction

  function automatic bit busy(input logic [64:0] wd);
    return !wd[32] || !wd[4];
  endfunction

  function automatic logic [4:0] first_req(input logic [4:0] r);
    for (int i = 0; i < 5; i++) if (r[i]) return 5'(1 << i);
    return 5'd0;
  endfunction

  function automatic logic [64:0] m_cs();
    logic [64:0] wd;
    wd = rom[m_upc];
    if (reset || m_halt) return nop_c;
    if (busy(wd) && !mem_ready) return wd & ~we_c;
    return wd;
  endfunction

  task automatic m_next();
    logic [64:0] wd;
    bit ok;
    int cc;
    if (reset) begin
      m_upc = 0; m_halt = 0; m_cb = 0; m_ack = 0; m_op = 0;
      return;
    end
    m_ack = 0;
    if (m_halt) begin
      if (wake) begin
        m_halt = 0;
        m_upc  = 0;
        if (INT_ON && ime) begin m_upc = 'h3F0; m_ack = first_req(irq_req); m_cb = 0; end
      end
      return;
    end
    wd = rom[m_upc];
    if (busy(wd) && !mem_ready) return;
    case (wd[31:30])
      2'd0: m_upc = (m_upc + 1) % 1024;
      2'd1: begin
        m_upc = (m_cb ? 512 : 0) + 2 * int'(inst_byte);
        m_op  = inst_byte;
        if (!m_cb && inst_byte == 8'h76) begin m_halt = 1; m_upc = 0; end
        m_cb = (inst_byte == 8'hCB) && !m_cb;
      end
      2'd2: begin
        cc = int'(m_op[4:3]);
        ok = (cc == 0) ? !flag_z : (cc == 1) ? flag_z : (cc == 2) ? !flag_c : flag_c;
        m_upc = ok ? (m_upc + 1) % 1024 : 0;
      end
      default: begin
        m_upc = 0;
        if (INT_ON && ime && irq_req != 0) begin m_upc = 'h3F0; m_ack = first_req(irq_req); m_cb = 0; end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at the falling edge with inputs applied; compares, then clocks once.
  task automatic step();
    #1;
    last_cs = control_signals; last_addr = int'(urom_addr);
    last_halted = halted; last_cb = cb_mode; last_ack = irq_ack;
    chk("cs", control_signals, m_cs());
    chk("addr", 65'(urom_addr), 65'(m_upc));
    chk("halted", 65'(halted), 65'(m_halt));
    chk("cb_mode", 65'(cb_mode), 65'(m_cb));
    chk("irq_ack", 65'(irq_ack), 65'(m_ack));
    m_next();
    @(posedge clock);
    @(negedge clock);
  endtask

  int exp_chain [4] = '{0, 1, 2, 3};
  logic [95:0] r96;

  initial begin
    nop_c = '0; nop_c[32] = 1'b1; nop_c[4] = 1'b1;
    we_c = '0;
    foreach (we_bits[i]) we_c[we_bits[i]] = 1'b1;
    for (int i = 0; i < 1024; i++) rom[i] = mkw(2'd3, 0, 0);
    m_upc = 0; m_halt = 0; m_cb = 0; m_op = 0; m_ack = 0;
    reset = 1; inst_byte = 0; flag_z = 0; flag_c = 0; mem_ready = 1;
    wake = 0; irq_req = 0; ime = 0;

    // Reset with a write-strobing word at address 0.
    rom[0] = mkw(2'd0, 0, 1);
    @(posedge clock); @(negedge clock);
    repeat (3) step();
    chk("rst_cs_nop", last_cs, nop_c);
    chk("rst_addr", 65'(last_addr), 65'd0);

    // NEXT chain 0,1,2,3 then END back to 0.
    rom[0] = mkw(2'd0, 0, 0); rom[1] = mkw(2'd0, 0, 0);
    rom[2] = mkw(2'd0, 0, 0); rom[3] = mkw(2'd3, 0, 0);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("next_chain", 65'(last_addr), 65'(exp_chain[i]));
    end
    rom[0] = mkw(2'd1, 0, 0);
    inst_byte = 8'hCB;
    step(); chk("chain_end", 65'(last_addr), 65'd0);

    // CB prefix, then CB-table dispatch of 0xFF lands at 3FE; NEXT wraps 3FF -> 000.
    rom['h196] = mkw(2'd3, 0, 0);
    rom['h3FE] = mkw(2'd0, 0, 0); rom['h3FF] = mkw(2'd0, 0, 0);
    step(); chk("cb_entry", 65'(last_addr), 65'h196); chk("cb_set", 65'(last_cb), 65'd1);
    inst_byte = 8'hFF;
    step();
    step(); chk("cb_disp", 65'(last_addr), 65'h3FE); chk("cb_clr", 65'(last_cb), 65'd0);
    step(); chk("pre_wrap", 65'(last_addr), 65'h3FF);
    inst_byte = 8'hCB;
    step(); chk("wrap", 65'(last_addr), 65'd0);
    inst_byte = 8'h37;
    step();

    // CB 0x37 -> map(1,0x37)=0x26E, a read word with bit 29 that waits 2 cycles.
    rom['h26E] = mkw(2'd3, 1, 0); rom['h26E][29] = 1'b1;
    step();
    mem_ready = 0;
    step(); chk("wait_addr0", 65'(last_addr), 65'h26E); chk("wait_we0", 65'(last_cs[29]), 65'd0);
    chk("disp37_cb", 65'(last_cb), 65'd0);
    step(); chk("wait_addr1", 65'(last_addr), 65'h26E); chk("wait_we1", 65'(last_cs[29]), 65'd0);
    mem_ready = 1;
    step(); chk("wait_addr2", 65'(last_addr), 65'h26E); chk("wait_we2", 65'(last_cs[29]), 65'd1);

    // COND with JP NZ (0xC2): Z=1 aborts to fetch, Z=0 falls through.
    rom['h184] = mkw(2'd2, 0, 0); rom['h185] = mkw(2'd3, 0, 0);
    inst_byte = 8'hC2;
    step();
    flag_z = 1;
    step(); chk("cond_at", 65'(last_addr), 65'h184);
    flag_z = 0;
    step(); chk("cond_false", 65'(last_addr), 65'd0);
    step();
    step(); chk("cond_true", 65'(last_addr), 65'h185);

    // HALT via 0x76, leave on wake.
    inst_byte = 8'h76;
    step();
    rom[0] = mkw(2'd3, 0, 0);
    step(); chk("halt_on", 65'(last_halted), 65'd1); chk("halt_nop", last_cs, nop_c);
    step(); chk("halt_hold", 65'(last_halted), 65'd1);
    wake = 1;
    step();
    wake = 0;
    step(); chk("halt_off", 65'(last_halted), 65'd0); chk("halt_addr", 65'(last_addr), 65'd0);

    // Interrupt at END.
    ime = 1; irq_req = 5'b00110;
    step();
    ime = 0; irq_req = 0;
    step();
`ifdef CU_INTERRUPT_EN
    chk("int_addr", 65'(last_addr), 65'h3F0); chk("int_ack", 65'(last_ack), 65'b00010);
`else
    chk("int_addr", 65'(last_addr), 65'd0); chk("int_ack", 65'(last_ack), 65'd0);
`endif
    step(); chk("int_ack_pulse", 65'(last_ack), 65'd0);

    // Randomized microcode and inputs.
    for (int i = 0; i < 1024; i++) begin
      r96 = {$urandom(), $urandom(), $urandom()};
      rom[i] = r96[64:0];
      rom[i][32] = ($urandom_range(3) != 0);
      rom[i][4]  = ($urandom_range(3) != 0);
    end
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(299) == 0);
      case ($urandom_range(5))
        0: inst_byte = 8'h76;
        1: inst_byte = 8'hCB;
        2: inst_byte = 8'hC2;
        3: inst_byte = 8'hDA;
        default: inst_byte = 8'($urandom());
      endcase
      flag_z = 1'($urandom()); flag_c = 1'($urandom());
      mem_ready = ($urandom_range(3) != 0);
      wake = ($urandom_range(3) == 0);
      ime = 1'($urandom()); irq_req = 5'($urandom());
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
